// File: rtl/race_game_ctrl.sv
// Per-frame game sequencer for the StellaRace racer. It handles lane input, obstacle
// scrolling, collision detection and scoring. Every change is committed one cycle after
// the sampled vertical-blank tick.
module race_game_ctrl #(
    parameter int unsigned PLAYER_Y     = 400,
    parameter int unsigned OBJ_H        = 32,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned SPEED_INIT   = 2,
    parameter int unsigned SPEED_MAX    = 8,
    parameter int unsigned CRASH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        movel,
    input  logic        mover,
    input  logic        start,
    output logic [1:0]  player_lane,
    output logic [1:0]  obs_lane,
    output logic [8:0]  obs_y,
    output logic [11:0] score,
    output logic [1:0]  state
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_CRASH = 2'b10;

    localparam int CW = $clog2(CRASH_FRAMES + 1);
    localparam logic [CW-1:0] CRASH_LAST   = CW'(CRASH_FRAMES - 1);
    localparam logic [CW-1:0] CRASH_ONE    = CW'(1);
    localparam logic [CW-1:0] CRASH_ZERO   = CW'(0);
    localparam logic [9:0]    SPEED_INIT_W = 10'(SPEED_INIT);
    localparam logic [9:0]    SPEED_MAX_W  = 10'(SPEED_MAX);
    localparam logic [9:0]    SCREEN_H_W   = 10'(SCREEN_H);
    localparam logic [9:0]    OBJ_H_W      = 10'(OBJ_H);
    localparam logic [9:0]    PLAYER_Y_W   = 10'(PLAYER_Y);
    localparam logic [9:0]    PLAYER_BOT_W = 10'(PLAYER_Y + OBJ_H);

    logic [7:0]    lfsr_r;
    logic [2:0]    btn_d1_r;
    logic [2:0]    btn_d2_r;
    logic [2:0]    btn_edge_s;
    logic          tick_r;
    logic          check_r;
    logic          pend_l_r, pend_l_s;
    logic          pend_r_r, pend_r_s;
    logic [CW-1:0] crash_cnt_r, crash_cnt_s;
    logic [1:0]    state_r, state_s;
    logic [1:0]    player_lane_r, player_lane_s;
    logic [1:0]    obs_lane_r, obs_lane_s;
    logic [8:0]    obs_y_r, obs_y_s;
    logic [11:0]   score_r, score_s;
    logic [9:0]    speed_raw_s;
    logic [9:0]    speed_s;
    logic [9:0]    obs_sum_s;
    logic          hit_s;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // bit 0 = left, bit 1 = right, bit 2 = start
    assign btn_edge_s = btn_d1_r & ~btn_d2_r;

    // Scroll speed from the pre-update score, wrap sum and collision test on current registers
    always_comb begin
        speed_raw_s = SPEED_INIT_W + {1'b0, score_r[11:3]};
        if (speed_raw_s > SPEED_MAX_W) begin
            speed_s = SPEED_MAX_W;
        end else begin
            speed_s = speed_raw_s;
        end
        obs_sum_s = {1'b0, obs_y_r} + speed_s;
        hit_s = (obs_lane_r == player_lane_r)
             && (({1'b0, obs_y_r} + OBJ_H_W) > PLAYER_Y_W)
             && ({1'b0, obs_y_r} < PLAYER_BOT_W);
    end

    // Input history, frame-tick stage and free-running LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r   <= 8'hA5;
            btn_d1_r <= 3'b000;
            btn_d2_r <= 3'b000;
            tick_r   <= 1'b0;
        end else begin
            lfsr_r   <= lfsr_step(lfsr_r);
            btn_d1_r <= {start, mover, movel};
            btn_d2_r <= btn_d1_r;
            tick_r   <= frame_tick;
        end
    end

    // Game state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (btn_edge_s[2]) state_s = ST_PLAY;
                else               state_s = ST_IDLE;
            end
            ST_PLAY: begin
                if (check_r && hit_s) state_s = ST_CRASH;
                else                  state_s = ST_PLAY;
            end
            ST_CRASH: begin
                if (tick_r && (crash_cnt_r == CRASH_LAST)) state_s = ST_IDLE;
                else                                       state_s = ST_CRASH;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of positions, score, pending moves and crash counter
    always_comb begin
        player_lane_s = player_lane_r;
        obs_lane_s    = obs_lane_r;
        obs_y_s       = obs_y_r;
        score_s       = score_r;
        crash_cnt_s   = crash_cnt_r;
        pend_l_s      = 1'b0;
        pend_r_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_edge_s[2]) begin
                    player_lane_s = 2'd1;
                    obs_lane_s    = 2'd0;
                    obs_y_s       = 9'd0;
                    score_s       = 12'd0;
                end else begin
                    score_s = score_r;
                end
            end
            ST_PLAY: begin
                // a press landing on the update cycle survives for the next frame
                pend_l_s = (pend_l_r & ~tick_r) | btn_edge_s[0];
                pend_r_s = (pend_r_r & ~tick_r) | btn_edge_s[1];
                if (tick_r) begin
                    if (pend_l_r && !pend_r_r) begin
                        player_lane_s = (player_lane_r == 2'd0) ? 2'd0 : player_lane_r - 2'd1;
                    end else if (pend_r_r && !pend_l_r) begin
                        player_lane_s = (player_lane_r == 2'd3) ? 2'd3 : player_lane_r + 2'd1;
                    end else begin
                        player_lane_s = player_lane_r;
                    end
                    if (obs_sum_s >= SCREEN_H_W) begin
                        obs_y_s    = 9'd0;
                        obs_lane_s = lfsr_r[1:0];
                        if (score_r != 12'hFFF) score_s = score_r + 12'd1;
                        else                    score_s = score_r;
                    end else begin
                        obs_y_s = obs_sum_s[8:0];
                    end
                end else if (check_r && hit_s) begin
                    crash_cnt_s = CRASH_ZERO;
                end else begin
                    crash_cnt_s = crash_cnt_r;
                end
            end
            ST_CRASH: begin
                if (tick_r) crash_cnt_s = crash_cnt_r + CRASH_ONE;
                else        crash_cnt_s = crash_cnt_r;
            end
            default: begin
                crash_cnt_s = CRASH_ZERO;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            player_lane_r <= 2'd1;
            obs_lane_r    <= 2'd0;
            obs_y_r       <= 9'd0;
            score_r       <= 12'd0;
            crash_cnt_r   <= CRASH_ZERO;
            pend_l_r      <= 1'b0;
            pend_r_r      <= 1'b0;
            check_r       <= 1'b0;
        end else begin
            player_lane_r <= player_lane_s;
            obs_lane_r    <= obs_lane_s;
            obs_y_r       <= obs_y_s;
            score_r       <= score_s;
            crash_cnt_r   <= crash_cnt_s;
            pend_l_r      <= pend_l_s;
            pend_r_r      <= pend_r_s;
            check_r       <= (state_r == ST_PLAY) && tick_r;
        end
    end

    assign player_lane = player_lane_r;
    assign obs_lane    = obs_lane_r;
    assign obs_y       = obs_y_r;
    assign score       = score_r;
    assign state       = state_r;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Self-checking bench for race_game_ctrl: directed game sequences plus randomized dodging,
// compared against a frame-level behavioural model of the game rules.
module tb_race_game_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        movel;
    logic        mover;
    logic        start;
    logic [1:0]  player_lane;
    logic [1:0]  obs_lane;
    logic [8:0]  obs_y;
    logic [11:0] score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    race_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .movel(movel), .mover(mover),
        .start(start), .player_lane(player_lane), .obs_lane(obs_lane), .obs_y(obs_y),
        .score(score), .state(state)
    );

    always #5 clk = ~clk;

    // reference LFSR, advanced every cycle from the reset seed
    logic [7:0] ref_lfsr;
    always @(posedge clk) ref_lfsr <= rst ? 8'hA5 : {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};

    // frame-level game model
    int m_state, m_lane, m_olane, m_oy, m_score, m_ccnt;
    bit m_pl, m_pr;
    int ticks_since_start;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        assert (got === 32'(exp)) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_lane = 1; m_olane = 0; m_oy = 0; m_score = 0;
        m_ccnt = 0; m_pl = 1'b0; m_pr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".player_lane"}, 32'(player_lane), m_lane);
        chk({tag, ".obs_lane"},    32'(obs_lane),    m_olane);
        chk({tag, ".obs_y"},       32'(obs_y),       m_oy);
        chk({tag, ".score"},       32'(score),       m_score);
        chk({tag, ".state"},       32'(state),       m_state);
    endtask

    // one frame of the game rules; vis is the state seen one cycle after the update
    task automatic model_frame(input int lfsr_lane, input bit l, input bit r, output int vis);
        int spd;
        vis = m_state;
        if (m_state == 1) begin
            if (m_pl && !m_pr)      m_lane = (m_lane > 0) ? m_lane - 1 : 0;
            else if (m_pr && !m_pl) m_lane = (m_lane < 3) ? m_lane + 1 : 3;
            spd = 2 + m_score / 8;
            if (spd > 8) spd = 8;
            if (m_oy + spd >= 480) begin
                m_oy = 0;
                m_olane = lfsr_lane;
                if (m_score < 4095) m_score++;
            end else begin
                m_oy = m_oy + spd;
            end
            m_pl = l; m_pr = r;
            if (m_olane == m_lane && m_oy + 32 > 400 && m_oy < 432) begin
                m_state = 2; m_ccnt = 0; m_pl = 1'b0; m_pr = 1'b0;
            end
        end else if (m_state == 2) begin
            m_ccnt++;
            if (m_ccnt == 60) m_state = 0;
            vis = m_state;
        end
    endtask

    task automatic do_tick(input bit l, input bit r);
        int lane_at, vis;
        frame_tick = 1'b1; movel = l; mover = r;
        cyc();
        frame_tick = 1'b0; movel = 1'b0; mover = 1'b0;
        lane_at = int'(ref_lfsr[1:0]);
        model_frame(lane_at, l, r, vis);
        ticks_since_start++;
        cyc();
        chk("tick.player_lane", 32'(player_lane), m_lane);
        chk("tick.obs_lane",    32'(obs_lane),    m_olane);
        chk("tick.obs_y",       32'(obs_y),       m_oy);
        chk("tick.score",       32'(score),       m_score);
        chk("tick.state_t1",    32'(state),       vis);
        cyc();
        chk("tick.state_t2",    32'(state),       m_state);
        cyc();
    endtask

    task automatic press(input bit l, input bit r);
        movel = l; mover = r;
        cyc();
        movel = 1'b0; mover = 1'b0;
        if (m_state == 1) begin
            m_pl = m_pl | l; m_pr = m_pr | r;
        end
        cyc();
        cyc();
    endtask

    task automatic start_btn(input bit with_tick);
        start = 1'b1; frame_tick = with_tick;
        cyc();
        start = 1'b0; frame_tick = 1'b0;
        if (m_state == 0) begin
            m_state = 1; m_lane = 1; m_olane = 0; m_oy = 0; m_score = 0;
            m_pl = 1'b0; m_pr = 1'b0;
            ticks_since_start = 0;
        end
        cyc();
        check_all("start_t1");
        cyc();
        check_all("start_t2");
        cyc();
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        int guard, pre_y, pre_s, sc, tgt;
        rst = 1'b1; frame_tick = 1'b0; movel = 1'b0; mover = 1'b0; start = 1'b0;
        ticks_since_start = 0;
        model_reset();

        // reset and idle ticks
        reset_pulse(2);
        repeat (10) do_tick(1'b0, 1'b0);

        // start and scroll
        start_btn(1'b0);
        chk("start_state", 32'(state), 1);
        do_tick(1'b0, 1'b0); chk("scroll1", 32'(obs_y), 2);
        do_tick(1'b0, 1'b0); chk("scroll2", 32'(obs_y), 4);
        do_tick(1'b0, 1'b0); chk("scroll3", 32'(obs_y), 6);

        // clamping, cancel, coincident press
        repeat (3) begin
            press(1'b1, 1'b0); do_tick(1'b0, 1'b0);
        end
        chk("clamp_left", 32'(player_lane), 0);
        press(1'b1, 1'b1); do_tick(1'b0, 1'b0);
        chk("both_cancel", 32'(player_lane), 0);
        press(1'b0, 1'b1); do_tick(1'b0, 1'b0);
        chk("move_right", 32'(player_lane), 1);
        do_tick(1'b1, 1'b0);
        chk("coincident_deferred", 32'(player_lane), 1);
        do_tick(1'b0, 1'b0);
        chk("coincident_applied", 32'(player_lane), 0);
        press(1'b0, 1'b1); do_tick(1'b0, 1'b0);

        // first wrap at tick 240
        guard = 0;
        while (score !== 12'd1 && guard < 300) begin
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("wrap_tick_count", 32'(ticks_since_start), 240);
        chk("wrap_obs_y", 32'(obs_y), 0);
        chk("wrap_score", 32'(score), 1);

        // randomized dodging up to the speed ceiling
        guard = 0;
        while (m_score < 50 && guard < 9000) begin
            guard++;
            if (m_olane == m_lane) begin
                if (m_lane == 0)                    press(1'b0, 1'b1);
                else if (m_lane == 3)               press(1'b1, 1'b0);
                else if ($urandom_range(1) == 0)    press(1'b0, 1'b1);
                else                                press(1'b1, 1'b0);
            end else if ($urandom_range(7) == 0) begin
                if ($urandom_range(3) == 0) begin
                    press(1'b1, 1'b1);
                end else if ($urandom_range(1) == 0) begin
                    tgt = (m_lane > 0) ? m_lane - 1 : 0;
                    if (tgt != m_olane) press(1'b1, 1'b0);
                end else begin
                    tgt = (m_lane < 3) ? m_lane + 1 : 3;
                    if (tgt != m_olane) press(1'b0, 1'b1);
                end
            end
            pre_y = m_oy; pre_s = m_score;
            do_tick(1'b0, 1'b0);
            if (m_oy != 0 && pre_s == 8)  chk("speed_at_8",  32'(int'(obs_y) - pre_y), 3);
            if (m_oy != 0 && pre_s >= 48) chk("speed_at_48", 32'(int'(obs_y) - pre_y), 8);
            repeat ($urandom_range(2)) cyc();
        end
        chk("dodge_reached_50", 32'(score >= 12'd50), 1);

        // steer into the obstacle, then run out the crash with score kept
        guard = 0;
        while (m_state == 1 && guard < 400) begin
            if (m_lane < m_olane)      press(1'b0, 1'b1);
            else if (m_lane > m_olane) press(1'b1, 1'b0);
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("crash_reached", 32'(state), 2);
        sc = m_score;
        repeat (60) do_tick(1'b0, 1'b0);
        chk("crash_idle", 32'(state), 0);
        chk("crash_score_kept", 32'(score), sc);

        // directed collision at obs_y 370
        reset_pulse(1);
        start_btn(1'b0);
        press(1'b1, 1'b0);
        repeat (184) do_tick(1'b0, 1'b0);
        chk("pre_band_obs_y", 32'(obs_y), 368);
        chk("pre_band_state", 32'(state), 1);
        do_tick(1'b0, 1'b0);
        chk("collide_obs_y", 32'(obs_y), 370);
        chk("collide_state", 32'(state), 2);
        repeat (30) do_tick(1'b0, 1'b0);
        start_btn(1'b0);
        chk("crash_start_ignored", 32'(state), 2);
        repeat (29) do_tick(1'b0, 1'b0);
        chk("crash_59", 32'(state), 2);
        do_tick(1'b0, 1'b0);
        chk("crash_60", 32'(state), 0);

        // start coincident with a tick, then reset mid-play with a pending move
        start_btn(1'b1);
        chk("start_tick_ignored", 32'(obs_y), 0);
        repeat (50) do_tick(1'b0, 1'b0);
        chk("mid_obs_y", 32'(obs_y), 100);
        press(1'b1, 1'b0);
        reset_pulse(1);
        start_btn(1'b0);
        do_tick(1'b0, 1'b0);
        chk("no_stale_move", 32'(player_lane), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
